uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Transmit path of the UART: takes bytes written to the THR register, buffers them in a small FIFO, and serialises them onto the TX pin as 8N1 frames at a fixed baud rate. Sits directly downstream of the UART register block, which issues a one-cycle push on every THR write. It also supplies the LSR THRE/TEMT status bits back to that block.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per serial bit (10 MHz / 115200); must be ≥ 2.
- FIFO_DEPTH, default 8: transmit FIFO entries; power of 2, ≥ 2.

- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  8  byte written to THR.
- i_write  in  1  one-cycle push strobe for i_data.
- o_full  out  1  FIFO holds FIFO_DEPTH bytes.
- o_thre  out  1  FIFO empty (LSR bit 5).
- o_temt  out  1  FIFO empty and serialiser idle (LSR bit 6).
- o_overflow  out  1  one-cycle pulse: a write was dropped.
- o_tx  out  1  serial line; idles high.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1).
- Every bit lasts exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state change.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The head is popped into the shift register in the same cycle.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits, tracked by a 3-bit bit index.
  - STOP → START on its last cycle if the FIFO is non-empty (pop in that cycle), so frames are contiguous with no idle gap. Otherwise STOP → IDLE.
- Push: accepted when !o_full, or when o_full and a pop occurs in the same cycle.
  - A rejected push drops the byte and pulses o_overflow for one cycle.
  - FIFO contents are unchanged by a rejected push.
- Simultaneous push and pop: count is unchanged and the byte is stored.
- Status outputs:
  - o_thre = (count == 0).
  - o_temt = (count == 0) && state == IDLE.
  - o_full = (count == FIFO_DEPTH).
- Count width: clog2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.
- Reset, including mid-frame: FIFO emptied, state IDLE, counters cleared, shift register cleared. A partial frame is truncated and o_tx is high on the cycle after reset is sampled.
- Reset values: o_tx=1, o_full=0, o_thre=1, o_temt=1, o_overflow=0.

## Timing
- o_tx is registered.
- Write latency, with FIFO empty and state IDLE:
  - i_write in cycle N → count=1 in N+1.
  - Pop in N+1 → o_tx low from N+2.
- Frame length: 10·CLKS_PER_BIT cycles. Back-to-back frames occupy exactly k·10·CLKS_PER_BIT cycles.
- o_thre and o_temt are combinational from registered state. They update the cycle after the push/pop/state change.
- o_temt rises the cycle after the last stop-bit cycle when no further data is queued.
- o_overflow asserts in the cycle after the rejected i_write.

## Structure
- Shared package uart_pkg holds:
  - FSM state encoding (tx_state_t).
  - LSR bit indices LSR_THRE=5, LSR_TEMT=6.
  - Frame constants (DATA_BITS=8).
- Sub-module uart_fifo: synchronous FIFO parameterised by WIDTH and DEPTH, with push/pop/full/empty/count. It is reused later by the receive path.
- Top level: FIFO instance, baud counter, bit index, shift register, FSM.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- Reset: hold i_reset 2 cycles → o_tx=1, o_thre=1, o_temt=1, o_full=0, o_overflow=0.
- Single byte:
  - Stimulus: write 0x41 at cycle N.
  - o_tx=0 during N+2..N+5.
  - Data bits 1,0,0,0,0,0,1,0, 4 cycles each.
  - Stop bit high during N+38..N+41.
  - o_temt=1 from N+42.
- Burst: write 0x55, 0xAA, 0x0F on consecutive cycles → three contiguous frames totalling 120 cycles with no idle cycle between them. o_thre=1 once the third byte is popped.
- Overflow:
  - Stimulus: 10 consecutive writes (0x00..0x09).
  - Writes 0..8 are accepted, with byte 0 already in the shifter; o_full=1 after the 9th.
  - The 10th is dropped with a one-cycle o_overflow.
  - The line emits 0x00..0x08 in order.
- Full + pop: with the FIFO full, issue a write in the exact cycle the STOP→START pop occurs → byte accepted, o_overflow stays 0, count stays 8.
- Mid-frame reset: assert i_reset during DATA bit 3 with 2 bytes queued → o_tx=1 the next cycle, o_temt=1, no further frames emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding,
// LSR status bit positions and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Register-block side of the UART transmitter:
// THR push path, LSR status bits and the serial line.
interface uart_transmitter_if;

  logic [7:0] i_data;
  logic       i_write;
  logic       o_full;
  logic       o_thre;
  logic       o_temt;
  logic       o_overflow;
  logic       o_tx;

  modport master (
    output i_data,
    output i_write,
    input  o_full,
    input  o_thre,
    input  o_temt,
    input  o_overflow,
    input  o_tx
  );

  modport slave (
    input  i_data,
    input  i_write,
    output o_full,
    output o_thre,
    output o_temt,
    output o_overflow,
    output o_tx
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO shared by
// the UART transmit and receive paths.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A full FIFO still takes a write when a pop frees a slot.
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;
  assign pop_data = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: THR FIFO feeding an 8N1 serialiser
// with back-to-back frames and LSR THRE/TEMT status.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  uart_transmitter_if.slave bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = cnt_width(FIFO_DEPTH);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST =
    BIT_IDX_W'(DATA_BITS - 1);

  tx_state_t              state;
  logic [BW-1:0]          baud;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   tx;
  logic                   ovf;

  logic [DATA_BITS-1:0]   head;
  logic                   full;
  logic                   empty;
  logic                   fifo_ovf;
  logic [CW-1:0]          count;
  logic                   baud_end;
  logic                   pop;

  assign baud_end = (baud == BAUD_LAST);

  // Pop from idle, or on the last stop cycle so the
  // next start bit follows with no idle gap.
  assign pop = !empty &&
    ((state == IDLE) ||
     ((state == STOP) && baud_end));

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (bus.i_write),
    .push_data (bus.i_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .overflow  (fifo_ovf),
    .count     (count)
  );

  // Frame sequencer; drives the registered line level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          if (pop) begin
            state <= START;
            shift <= head;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BIT_IDX_W'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              state <= START;
              shift <= head;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          baud  <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // Dropped-write pulse, one cycle after the rejected push.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= fifo_ovf;
    end
  end

  assign bus.o_tx       = tx;
  assign bus.o_full     = full;
  assign bus.o_thre     = (count == '0);
  assign bus.o_temt     = (count == '0) && (state == IDLE);
  assign bus.o_overflow = ovf;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: cycle-level reference model
// of the line and FIFO plus directed timing scenarios.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_transmitter_if bus();

  uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] q[$];
  bit         has_frame = 0;
  int         fstart    = 0;
  logic [7:0] fbyte     = '0;
  bit         ovf_exp   = 0;
  bit         line[int];

  function automatic bit frame_on(input int c);
    return has_frame && (c > fstart) && (c <= fstart + FRAME);
  endfunction

  function automatic logic exp_tx(input int c);
    int b;
    if (!frame_on(c)) return 1'b1;
    b = (c - fstart - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return fbyte[b-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] decode(input int s);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[k] = line[s + CPB * (k + 1) + CPB / 2];
    end
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h cycle %0d",
             tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance model, compare all.
  task automatic step(input bit w,
                      input logic [7:0] d,
                      input bit r);
    bit idle_now;
    bit pop;
    bit acc;
    bus.i_write = w;
    bus.i_data  = d;
    rst         = r;
    idle_now    = !frame_on(cyc);
    if (r) begin
      q.delete();
      has_frame = 0;
      ovf_exp   = 0;
    end else begin
      pop = (q.size() > 0) &&
            (idle_now || (cyc == fstart + FRAME));
      if (pop) begin
        fbyte     = q.pop_front();
        fstart    = cyc;
        has_frame = 1;
      end
      acc = w && (q.size() < DEPTH);
      if (acc) q.push_back(d);
      ovf_exp = w && !acc;
    end
    @(posedge clk);
    cyc++;
    #1;
    line[cyc] = bus.o_tx;
    chk("tx",   bus.o_tx,   exp_tx(cyc));
    chk("thre", bus.o_thre, q.size() == 0);
    chk("temt", bus.o_temt,
        (q.size() == 0) && !frame_on(cyc));
    chk("full", bus.o_full, q.size() == DEPTH);
    chk("ovf",  bus.o_overflow, ovf_exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(bus.o_temt === 1'b1) && k < 2000) begin
      step(0, 8'h00, 0);
      k++;
    end
    chk("drain_timeout", bus.o_temt, 1'b1);
  endtask

  int n;
  int low_at;
  int temt_at;

  initial begin
    bus.i_write = 1'b0;
    bus.i_data  = 8'h00;

    // Reset held two cycles.
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("rst_tx",   bus.o_tx,       1'b1);
    chk("rst_thre", bus.o_thre,     1'b1);
    chk("rst_temt", bus.o_temt,     1'b1);
    chk("rst_full", bus.o_full,     1'b0);
    chk("rst_ovf",  bus.o_overflow, 1'b0);
    idle(3);

    // Single byte 0x41.
    n = cyc;
    low_at  = -1;
    temt_at = -1;
    step(1, 8'h41, 0);
    for (int i = 0; i < 50; i++) begin
      step(0, 8'h00, 0);
      if (low_at < 0 && bus.o_tx === 1'b0) low_at = cyc;
      if (temt_at < 0 && cyc > n + 2 && bus.o_temt === 1'b1)
        temt_at = cyc;
    end
    chk("single_start", 8'(low_at - n), 8'd2);
    chk("single_temt",  8'(temt_at - n), 8'd42);
    chk("single_data",  decode(n + 2), 8'h41);
    chk("single_stop",  line[n + 38] & line[n + 41], 1'b1);

    // Burst of three contiguous frames.
    n = cyc;
    step(1, 8'h55, 0);
    step(1, 8'hAA, 0);
    step(1, 8'h0F, 0);
    while (cyc < n + 81) step(0, 8'h00, 0);
    chk("burst_thre_pre", bus.o_thre, 1'b0);
    step(0, 8'h00, 0);
    chk("burst_thre", bus.o_thre, 1'b1);
    temt_at = -1;
    for (int i = 0; i < 60 && temt_at < 0; i++) begin
      step(0, 8'h00, 0);
      if (bus.o_temt === 1'b1) temt_at = cyc;
    end
    chk("burst_len", 8'(temt_at - (n + 2)), 8'd120);
    chk("burst_b0", decode(n + 2), 8'h55);
    chk("burst_b1", decode(n + 2 + FRAME), 8'hAA);
    chk("burst_b2", decode(n + 2 + 2 * FRAME), 8'h0F);

    // Overflow, then a write during the full-FIFO pop.
    idle(5);
    n = cyc;
    for (int i = 0; i < 10; i++) step(1, 8'(i), 0);
    chk("ovf_pulse", bus.o_overflow, 1'b1);
    step(0, 8'h00, 0);
    chk("ovf_clear", bus.o_overflow, 1'b0);
    chk("ovf_full",  bus.o_full,     1'b1);
    while (cyc < n + 41) step(0, 8'h00, 0);
    chk("fp_full_pre", bus.o_full, 1'b1);
    step(1, 8'hC3, 0);
    chk("fp_ovf",  bus.o_overflow, 1'b0);
    chk("fp_full", bus.o_full,     1'b1);
    drain();
    for (int j = 0; j < 10; j++) begin
      chk("ovf_order", decode(n + 2 + j * FRAME),
          (j < 9) ? 8'(j) : 8'hC3);
    end

    // Reset during data bit 3 with two bytes queued.
    idle(3);
    n = cyc;
    step(1, 8'hA1, 0);
    step(1, 8'hB2, 0);
    step(1, 8'hC3, 0);
    while (cyc < n + 19) step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    chk("mrst_tx",   bus.o_tx,   1'b1);
    chk("mrst_temt", bus.o_temt, 1'b1);
    low_at = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(0, 8'h00, 0);
      if (bus.o_tx !== 1'b1) low_at++;
    end
    chk("mrst_quiet", 8'(low_at), 8'd0);

    // Randomised writes against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 5) == 0, 8'($urandom), 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
